// File: rtl/mm_result_drain.sv
// Streams the accumulator register file out, word 0..DEPTH-1, on a valid/ready
// port once a matrix multiply finishes. A 2-entry FIFO absorbs the read latency.
module mm_result_drain #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_acc_rd,
  output logic [ADDR_W-1:0] o_acc_addr,
  input  logic [DATA_W-1:0] i_acc_rdata,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] last_addr;
  logic              issued;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [2:0]        occ;
  logic              vld_p1, last_p1;
  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_last [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        cnt;
  logic              push, pop;

  // A word popped this cycle frees its slot in time for a read issued now,
  // which is what sustains one word per cycle without ever exceeding 2 entries.
  always_comb begin
    push     = vld_p1;
    o_valid  = (cnt != 2'd0);
    pop      = o_valid & i_ready;
    occ      = {1'b0, cnt} + {2'b00, vld_p1} - {2'b00, pop};
    rd_addr  = issued ? (last_addr + ADDR_W'(1)) : '0;
    rd_en    = (state == RUN) && (occ < 3'd2);
    o_acc_rd   = rd_en;
    o_acc_addr = rd_en ? rd_addr : last_addr;
    o_data   = o_valid ? fifo_data[rd_ptr] : '0;
    o_last   = o_valid & fifo_last[rd_ptr];
    o_busy   = (state == RUN) || (state == FLUSH);
    o_done   = (state == DONE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_start) state_nxt = RUN;
      RUN:   if (rd_en && (rd_addr == LAST_ADDR)) state_nxt = FLUSH;
      FLUSH: if (pop && o_last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      last_addr <= '0;
      issued    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rd_en) begin
        last_addr <= rd_addr;
        issued    <= 1'b1;
      end else if (state == DONE) begin
        issued <= 1'b0;
      end
    end
  end

  // Stage p1: register-file read in flight, tagged with its last-word flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= rd_en;
      last_p1 <= rd_en && (rd_addr == LAST_ADDR);
    end
  end

  // Stage p2: output FIFO
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= i_acc_rdata;
      fifo_last[wr_ptr] <= last_p1;
    end
  end

endmodule

// File: tb/tb_mm_result_drain.sv
// Bench for mm_result_drain: register-file model, scoreboard of expected words,
// a cycle table for start-up latency/backpressure and directed multi-cycle cases.
module tb_mm_result_drain;

  localparam int DEPTH  = 1024;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, acc_rd;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_rdata;
  logic              valid, ready, last;
  logic [DATA_W-1:0] data;

  mm_result_drain #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
    .o_acc_rd(acc_rd), .o_acc_addr(acc_addr), .i_acc_rdata(acc_rdata),
    .o_valid(valid), .i_ready(ready), .o_data(data), .o_last(last)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) if (acc_rd) acc_rdata <= mem[acc_addr];

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [DATA_W-1:0] pat_val(int p, int i);
    if (p == 0) return DATA_W'(i * 3 + 24'h100000);
    return DATA_W'(24'hFFFFFF - i);
  endfunction

  typedef struct packed { logic [DATA_W-1:0] data; logic last; } exp_t;
  exp_t sb[$];

  // Drain statistics, maintained by the monitor, cleared at each start
  int words_seen, done_cnt, rd_cnt, valid_cnt, outst;
  int first_valid, last_valid, done_cyc, start_cyc;
  int exp_rd_addr;
  logic [DATA_W-1:0] first_data, last_data, prev_data;
  logic prev_stall, prev_last;
  logic rnd = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", valid, 1);
        chk("stall_data", data, prev_data);
        chk("stall_last", last, prev_last);
      end
      if (acc_rd) begin
        chk("rd_addr", acc_addr, exp_rd_addr);
        exp_rd_addr++;
        rd_cnt++;
        outst++;
      end
      if (valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
      end
      if (valid && ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", data, e.data);
          chk("out_last", last, e.last);
        end
        if (words_seen == 0) first_data = data;
        if (last) last_data = data;
        words_seen++;
        outst--;
      end
      if (acc_rd || (valid && ready)) chk("outstanding_le2", outst > 2, 0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = valid && !ready;
      prev_data  = data;
      prev_last  = last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    if (rnd) ready = 1'($urandom % 2);
  endtask

  task automatic load_mem(int p);
    for (int i = 0; i < DEPTH; i++) mem[i] = pat_val(p, i);
  endtask

  // Called at posedge+1: raises i_start for this cycle and queues the stream
  task automatic start_drain(int p);
    sb.delete();
    for (int i = 0; i < DEPTH; i++) sb.push_back('{data: pat_val(p, i), last: (i == DEPTH - 1)});
    words_seen = 0; done_cnt = 0; rd_cnt = 0; valid_cnt = 0; outst = 0;
    first_valid = -1; last_valid = -1; done_cyc = -1; exp_rd_addr = 0;
    first_data = '0; last_data = '0;
    start_cyc = cyc;
    start = 1'b1;
  endtask

  task automatic wait_done(int bound);
    for (int n = 0; n < bound; n++) begin
      tick();
      if (done_cnt > 0) break;
    end
    chk("done_seen", done_cnt > 0, 1);
  endtask

  task automatic end_checks(string nm);
    repeat (3) tick();
    chk({nm, "_words"}, words_seen, DEPTH);
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_sb_empty"}, sb.size(), 0);
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_rd"}, acc_rd, 0);
    chk({nm, "_addr"}, acc_addr, 0);
    chk({nm, "_valid"}, valid, 0);
    chk({nm, "_data"}, data, 0);
    chk({nm, "_last"}, last, 0);
  endtask

  typedef struct {
    logic              start, ready, rd;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              busy, done;
  } vec_t;
  vec_t tbl [10];

  initial begin
    // Cycle-by-cycle from the start cycle C, with a two-cycle stall at C+5/C+6
    tbl[0] = '{1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 24'h000000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 10'd0, 1'b0, 24'h000000, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 10'd1, 1'b0, 24'h000000, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 10'd2, 1'b1, 24'h100000, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 10'd3, 1'b1, 24'h100003, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 10'd3, 1'b1, 24'h100006, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 10'd3, 1'b1, 24'h100006, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 10'd4, 1'b1, 24'h100006, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 10'd5, 1'b1, 24'h100009, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 10'd6, 1'b1, 24'h10000C, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; ready = 1'b0;
    words_seen = 0; done_cnt = 0; rd_cnt = 0; valid_cnt = 0; outst = 0;
    first_valid = -1; last_valid = -1; done_cyc = -1; start_cyc = 0; exp_rd_addr = 0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Start-up latency and a short stall, table driven
    load_mem(0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      ready = tbl[k].ready;
      if (tbl[k].start) start_drain(0);
      @(negedge clk);
      chk($sformatf("tbl%0d_rd", k), acc_rd, tbl[k].rd);
      chk($sformatf("tbl%0d_addr", k), acc_addr, tbl[k].addr);
      chk($sformatf("tbl%0d_valid", k), valid, tbl[k].valid);
      chk($sformatf("tbl%0d_data", k), data, tbl[k].data);
      chk($sformatf("tbl%0d_busy", k), busy, tbl[k].busy);
      chk($sformatf("tbl%0d_done", k), done, tbl[k].done);
    end
    ready = 1'b1;
    wait_done(3000);
    chk("tbl_done_cycle", done_cyc - start_cyc, 1029);
    end_checks("tbl");

    // Full drain, ready tied high
    ready = 1'b1;
    start_drain(0);
    wait_done(3000);
    chk("full_first_valid", first_valid - start_cyc, 3);
    chk("full_last_valid", last_valid - start_cyc, 1026);
    chk("full_valid_cycles", valid_cnt, DEPTH);
    chk("full_done_cycle", done_cyc - start_cyc, 1027);
    chk("full_last_word", last_data, 24'h100BFD);
    end_checks("full");

    // Random backpressure
    rnd = 1'b1;
    start_drain(0);
    wait_done(6000);
    rnd = 1'b0;
    ready = 1'b1;
    end_checks("rand");

    // Ready low for 20 cycles right after start
    ready = 1'b0;
    start_drain(0);
    repeat (20) tick();
    @(negedge clk);
    #1;
    chk("stall20_reads", rd_cnt, 2);
    chk("stall20_valid", valid, 1);
    chk("stall20_data", data, 24'h100000);
    tick();
    ready = 1'b1;
    wait_done(3000);
    end_checks("stall20");

    // Second start mid-drain is ignored
    ready = 1'b1;
    start_drain(0);
    for (int n = 0; n < 2000 && words_seen < 500; n++) tick();
    start = 1'b1;
    tick();
    chk("midstart_busy", busy, 1);
    wait_done(3000);
    end_checks("midstart");

    // Asynchronous reset during word 300, then a clean restart
    start_drain(0);
    for (int n = 0; n < 2000 && words_seen < 300; n++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    tick();
    chk("midrst_idle", busy, 0);
    start_drain(0);
    wait_done(3000);
    chk("restart_first_word", first_data, 24'h100000);
    end_checks("restart");

    // Back-to-back drains with a new pattern
    start_drain(0);
    wait_done(3000);
    chk("b2b1_words", words_seen, DEPTH);
    chk("b2b1_sb_empty", sb.size(), 0);
    load_mem(1);
    start_drain(1);
    wait_done(3000);
    chk("b2b2_first_word", first_data, 24'hFFFFFF);
    chk("b2b2_last_word", last_data, 24'hFFFC00);
    end_checks("b2b2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mm_result_drain.md
Name: mm_result_drain

Overview:
- Reader-side counterpart to mm_ctrl. mm_ctrl writes the 1024 x 24-bit results of a matrix multiply into the accumulator register file. This block reads those results back out.
- After the matrix multiply completes, it walks the register file sequentially and streams every word out on a valid/ready interface, marking the final word with o_last.
- Sits between the accumulator register file and the downstream output or host interface.

Parameters:
- DEPTH, 1024, number of accumulator words to drain.
- DATA_W, 24, accumulator word width.
- ADDR_W, 10, register-file address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse, normally tied to mm_ctrl o_done; begins a drain.
- o_busy  out  1  high from the cycle after start is accepted until o_done.
- o_done  out  1  one-cycle pulse after the last word handshakes.
- o_acc_rd  out  1  register-file read enable.
- o_acc_addr  out  ADDR_W  register-file read address.
- i_acc_rdata  in  DATA_W  read data, valid exactly 1 cycle after o_acc_rd.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream ready.
- o_data  out  DATA_W  output word; the register-file word, unmodified.
- o_last  out  1  high with o_valid on word DEPTH-1.

Behaviour:
- Reset (asynchronous, any time, including mid-drain) clears all outputs and internal state to 0:
  - o_busy, o_done, o_acc_rd, o_acc_addr, o_valid, o_data and o_last are all 0.
  - FSM returns to IDLE, the FIFO is emptied, and the read pointer and output count are cleared.
  - Any in-flight read is discarded.
- FSM states:
  - IDLE: i_start=1 -> RUN.
  - RUN: issues reads. Moves to FLUSH after the read for address DEPTH-1 has been issued.
  - FLUSH: no further reads. Moves to DONE when word DEPTH-1 handshakes (o_valid & i_ready).
  - DONE: o_done=1 for one cycle, then -> IDLE.
- i_start is ignored outside IDLE. No queuing, no restart.
- Buffering: 2-entry output FIFO.
  - A read may be issued in a cycle only if (FIFO count + reads in flight) < 2.
  - This guarantees no overflow under arbitrary i_ready patterns.
  - When i_acc_rdata arrives, it is written into the FIFO.
- o_valid = FIFO not empty. o_data and o_last come from the FIFO head.
- A FIFO push and pop may occur in the same cycle; the count is then unchanged.
- Addresses are issued strictly in order 0..DEPTH-1, each exactly once. Output order equals address order.
- o_acc_addr holds its last value when o_acc_rd=0.
- Latency, with i_start high in cycle C:
  - C+1: o_acc_rd=1 with o_acc_addr=0; o_busy=1.
  - C+3: o_valid=1 with word 0 on o_data.
- Throughput: with i_ready held high, one word per cycle. Words 0..DEPTH-1 appear in C+3..C+DEPTH+2; o_done pulses in C+DEPTH+3.
- Backpressure: while o_valid=1 and i_ready=0, o_data and o_last stay stable. Once the FIFO is full, reads stall.
- o_busy drops in the same cycle that o_done pulses.
- Output word count wraps only via the FSM, never by counter overflow. The address counter must not increment past DEPTH-1.

Test Plan:
- Full drain with i_ready tied high:
  - Preload the register file with mem[i] = i*3 + 0x100000, then pulse i_start in cycle C.
  - Required: 1024 words in order, a contiguous valid run C+3..C+1026, o_last only on word 1023 (value 0x100BFD), o_done single pulse at C+1027.
- Random backpressure:
  - i_ready random at 50%, same data.
  - Required: every word exactly once and in order; o_data stable while stalled; never more than 2 reads outstanding/buffered; no overflow.
- i_ready low for 20 cycles right after start:
  - Required: exactly 2 reads issued (addresses 0 and 1), then o_acc_rd=0 until the first pop; word 0 is held on o_data throughout.
- i_start pulsed again mid-drain (at word 500):
  - Required: ignored; the stream continues uninterrupted to word 1023; exactly one o_done.
- Reset asserted during word 300:
  - Required: all outputs 0 immediately (asynchronous); state IDLE.
  - A following i_start restarts from address 0 and drains all 1024 words correctly.
- Back-to-back drains:
  - i_start in the cycle after o_done, with a new data pattern mem[i] = 0xFFFFFF - i.
  - Required: second stream correct, first word 0xFFFFFF, last word 0xFFFC00.
